// File: rtl/odo_work_loader_pkg.sv
// Shared definitions for the work loader: command codes, default payload
// sizes and FSM state encodings. Host software is generated from the same
// values, so keep them in step with the host side.
package odo_work_loader_pkg;

  localparam int HDR_BYTES_DEF = 76;
  localparam int TGT_BYTES_DEF = 32;

  localparam logic [7:0] ODO_CMD_LOAD_HDR = 8'h01;
  localparam logic [7:0] ODO_CMD_LOAD_TGT = 8'h02;
  localparam logic [7:0] ODO_CMD_COMMIT   = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_TGT    = 3'd2,
    ST_CHK    = 3'd3,
    ST_COMMIT = 3'd4
  } ld_state_e;

  // Index of the last payload byte, sized for the 7-bit byte counter.
  function automatic logic [6:0] last_idx(input int n);
    return 7'(n - 1);
  endfunction

endpackage

// File: rtl/odo_shift_in.sv
// Byte-wide shift register feeding one shadow register (header or target).
// Bytes shift in from the top so payload byte 0 ends up in bits [7:0].
// The shift happens in a staging register; fin_en copies it into the shadow,
// so a load that is abandoned or rejected never touches the shadow.
// Optional feature: ODO_LOADER_CHECKSUM_EN adds an XOR accumulator and a
// checksum compare on the byte presented with fin_en.
module odo_shift_in #(
  parameter int BYTES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               shift_en,
  input  logic               fin_en,
  output logic [BYTES*8-1:0] shadow,
  output logic               sum_bad
);

  localparam int W = BYTES * 8;

  logic [W-1:0] stage_q;
  logic [W-1:0] stage_d;

  // Next staging value: shift one byte in from the top when enabled.
  always_comb begin
    stage_d = shift_en ? {in_data, stage_q[W-1:8]} : stage_q;
  end

`ifdef ODO_LOADER_CHECKSUM_EN
  logic [7:0] xsum_q;

  // fin_en arrives with the checksum byte; compare it to the running XOR.
  assign sum_bad = fin_en && (in_data != xsum_q);

  // Running XOR of payload bytes, restarted after every checksum byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsum_q <= '0;
    end else if (fin_en) begin
      xsum_q <= '0;
    end else if (shift_en) begin
      xsum_q <= xsum_q ^ in_data;
    end
  end
`else
  assign sum_bad = 1'b0;
`endif

  // Staging register and shadow; the shadow only takes a completed, accepted load.
  // NOTE: these wide registers get a reset because a reset mid-load must leave
  // the shadows at zero; plain data storage would normally skip the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      shadow  <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples the pre-edge values, independent of statement order.
      stage_q <= stage_d;
      if (fin_en && !sum_bad) begin
        shadow <= stage_d;
      end
    end
  end

endmodule

// File: rtl/odo_work_loader.sv
// Host-side work feeder for the miner. Parses a byte command stream, fills
// header/target shadows, and swaps them into the live outputs on COMMIT so
// the miner never sees a partially written header.
// Optional feature: ODO_LOADER_CHECKSUM_EN appends one XOR checksum byte to
// every LOAD payload; a mismatch sets cmd_err and discards the load.
module odo_work_loader
  import odo_work_loader_pkg::*;
#(
  parameter int HDR_BYTES = HDR_BYTES_DEF,
  parameter int TGT_BYTES = TGT_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [HDR_BYTES*8-1:0] header,
  output logic [TGT_BYTES*8-1:0] target,
  output logic                   work_new,
  output logic                   cmd_err
);

  ld_state_e state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       live_q;
  logic       accept;
  logic       hdr_shift, tgt_shift, hdr_fin, tgt_fin;
  logic       bad_cmd, do_commit;
  logic       hdr_bad, tgt_bad;
  logic [HDR_BYTES*8-1:0] hdr_shadow;
  logic [TGT_BYTES*8-1:0] tgt_shadow;
`ifdef ODO_LOADER_CHECKSUM_EN
  logic       sel_tgt_q, sel_tgt_d;
`endif

  // live_q holds in_ready low until the first edge after reset releases.
  assign in_ready = live_q && (state_q != ST_COMMIT);
  assign accept   = in_valid && in_ready;
  // The COMMIT state is exactly the cycle in which the new work is live.
  assign work_new = (state_q == ST_COMMIT);

  // Command decode, payload counting and shadow strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_shift = 1'b0;
    tgt_shift = 1'b0;
    hdr_fin   = 1'b0;
    tgt_fin   = 1'b0;
    bad_cmd   = 1'b0;
    do_commit = 1'b0;
`ifdef ODO_LOADER_CHECKSUM_EN
    sel_tgt_d = sel_tgt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_data == ODO_CMD_LOAD_HDR) begin
            state_d = ST_HDR;
            cnt_d   = '0;
`ifdef ODO_LOADER_CHECKSUM_EN
            sel_tgt_d = 1'b0;
`endif
          end else if (in_data == ODO_CMD_LOAD_TGT) begin
            state_d = ST_TGT;
            cnt_d   = '0;
`ifdef ODO_LOADER_CHECKSUM_EN
            sel_tgt_d = 1'b1;
`endif
          end else if (in_data == ODO_CMD_COMMIT) begin
            // Live registers load on this edge so they are valid in ST_COMMIT.
            state_d   = ST_COMMIT;
            do_commit = 1'b1;
          end else begin
            bad_cmd = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (accept) begin
          hdr_shift = 1'b1;
          if (cnt_q == last_idx(HDR_BYTES)) begin
            cnt_d = '0;
`ifdef ODO_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            hdr_fin = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ST_TGT: begin
        if (accept) begin
          tgt_shift = 1'b1;
          if (cnt_q == last_idx(TGT_BYTES)) begin
            cnt_d = '0;
`ifdef ODO_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            tgt_fin = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ST_CHK: begin
`ifdef ODO_LOADER_CHECKSUM_EN
        if (accept) begin
          hdr_fin = !sel_tgt_q;
          tgt_fin = sel_tgt_q;
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state, byte counter and the out-of-reset flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      live_q  <= 1'b0;
`ifdef ODO_LOADER_CHECKSUM_EN
      sel_tgt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
`ifdef ODO_LOADER_CHECKSUM_EN
      sel_tgt_q <= sel_tgt_d;
`endif
    end
  end

  // Live work registers: change only on COMMIT, both in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      header <= '0;
      target <= '0;
    end else if (do_commit) begin
      header <= hdr_shadow;
      target <= tgt_shadow;
    end
  end

  // Sticky error flag, cleared by the next successful COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err <= 1'b0;
    end else if (do_commit) begin
      cmd_err <= 1'b0;
    end else if (bad_cmd || hdr_bad || tgt_bad) begin
      cmd_err <= 1'b1;
    end
  end

  odo_shift_in #(.BYTES(HDR_BYTES)) u_hdr_shift (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .shift_en (hdr_shift),
    .fin_en   (hdr_fin),
    .shadow   (hdr_shadow),
    .sum_bad  (hdr_bad)
  );

  odo_shift_in #(.BYTES(TGT_BYTES)) u_tgt_shift (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .shift_en (tgt_shift),
    .fin_en   (tgt_fin),
    .shadow   (tgt_shadow),
    .sum_bad  (tgt_bad)
  );

endmodule
